sdmf_expand_split: RTL and testbench
====================================

// Module: sdmf_expand_split
// PURPOSE
//  Inverse of the SDMF reduce/merge path. Takes one merged SDMF frame: header (FDSTI, FDSSI), then
//  2**O_TAM_WIDTH sub-frames of 2**SUB_WORDS_LOG2 words each. Re-emits each sub-frame as its own SDMF frame.
//  Per frame: own FI_valid header, FDSTI = {in_FDSTI, sub_idx}, narrowed tdata. Sits at the expand end of the link.
// PARAMETERS
//  I_FDSTI_WIDTH    28  input FDSTI width
//  I_FDSSI_WIDTH    12  FDSSI width, passed through unchanged
//  O_TAM_WIDTH      4   sub-frame index width; output FDSTI width = I_FDSTI_WIDTH+O_TAM_WIDTH
//  I_DATA_WIDTH     24  input word width; bits [I_DATA_WIDTH-1:O_DATA_WIDTH] are the tag field
//  O_DATA_WIDTH     16  output word width (payload = in tdata[O_DATA_WIDTH-1:0]); I_DATA_WIDTH-O_DATA_WIDTH >= O_TAM_WIDTH
//  SUB_WORDS_LOG2   4   log2 of words per sub-frame
// PORTS
//  clk                  in   1     clock
//  reset                in   1     synchronous, active-high reset
//  SDMFi_d_frame_valid  in   1     input frame envelope
//  SDMFi_d_FI_valid     in   1     input header strobe; FDSTI/FDSSI valid this cycle
//  SDMFi_d_FDSTI        in   I_FDSTI_WIDTH   input frame time index
//  SDMFi_d_FDSSI        in   I_FDSSI_WIDTH   input frame space index
//  SDMFi_d_tvalid/tready/tlast  in/out/in  1  input AXI-stream handshake
//  SDMFi_d_tdata        in   I_DATA_WIDTH    input word
//  SDMFo_d_frame_valid  out  1     output sub-frame envelope
//  SDMFo_d_FI_valid     out  1     output header strobe (1-cycle pulse)
//  SDMFo_d_FDSTI        out  I_FDSTI_WIDTH+O_TAM_WIDTH  {captured FDSTI, sub_idx}
//  SDMFo_d_FDSSI        out  I_FDSSI_WIDTH   captured FDSSI
//  SDMFo_d_tvalid/tready/tlast  out/in/out  1  output AXI-stream handshake
//  SDMFo_d_tdata        out  O_DATA_WIDTH    output word
//  err_short            out  1     sticky: input tlast arrived before the frame was complete
//  err_long             out  1     sticky: no input tlast at the expected last word
//  err_tag              out  1     sticky tag mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, sticky errors cleared; partial frames are discarded, never resumed.
//  FSM states and transitions:
//  - IDLE:     SDMFi_d_FI_valid=1 -> latch FDSTI/FDSSI, sub_idx=0 -> S_HDR. FI_valid outside IDLE is ignored.
//  - S_HDR:    one cycle; frame_valid=1, FI_valid=1, header outputs stable -> S_DATA.
//  - S_DATA:   zero-latency pass-through. SDMFo_d_tvalid=SDMFi_d_tvalid, SDMFi_d_tready=SDMFo_d_tready,
//              tdata=in[O_DATA_WIDTH-1:0]. word_cnt advances on each in-handshake.
//              * word_cnt==2**SUB_WORDS_LOG2-1: SDMFo_d_tlast=1 -> S_GAP.
//              * In tlast earlier: forward that word with out tlast=1, set err_short, -> S_GAP, then IDLE
//                (remaining sub-frames are not emitted).
//              * Last word of last sub-frame without in tlast: set err_long -> DRAIN.
//  - S_GAP:    one cycle; frame_valid=0, tvalid=0. Next state S_HDR with sub_idx+1, or IDLE after the last
//              sub-frame or a short frame.
//  - DRAIN:    SDMFi_d_tready=1, words dropped, no output -> IDLE on in tlast handshake.
//  Output frame_valid is high from S_HDR through the tlast handshake. FDSTI/FDSSI are held stable for the
//  whole sub-frame.
//  Latency: in FI_valid at edge N -> out FI_valid in cycle N+1; first data cycle N+2.
//  SDMFi_d_tready is 0 in IDLE, S_HDR and S_GAP. Input stalls and output stalls both freeze word_cnt.
//  Wrap-around: sub_idx and word_cnt reset to 0 at each new frame; there is no wrap within a frame.
//  SDMFi_d_frame_valid is informational only and does not gate the FSM.
// CONFIGURATION
//  SDMF_EXPAND_TAGCHK_EN defined:
//   - On each in-handshake in S_DATA, compare tdata[O_DATA_WIDTH+O_TAM_WIDTH-1:O_DATA_WIDTH] with sub_idx.
//   - Mismatch sets err_tag (sticky until reset). Data is forwarded regardless.
//  Not defined: err_tag tied to 0; no compare logic is built.
// STRUCTURE
//  - Package sdmf_expand_pkg: FSM state enum (IDLE,S_HDR,S_DATA,S_GAP,DRAIN); function for output FDSTI width.
//  - Sub-module sdmf_expand_cnt: word_cnt/sub_idx counter pair with last_word/last_sub flags.
// TESTING
//  1 Nominal, defaults: FDSTI=0x0000123, FDSSI=0x5; 256 words, tlast on word 255 -> 16 out frames with FDSTI
//    0x00001230..0x0000123F, 16 words each, tlast on every 16th word, 1 idle cycle between frames.
//  2 Output backpressure (tready toggling 1-0): identical word sequence and count; no loss, no duplication.
//  3 Early tlast on word 40 -> frame 2 ends at its word 8 with tlast; err_short=1; next FI_valid starts cleanly.
//  4 No tlast at word 255; tlast at word 260 -> 16 frames emitted; words 256..260 dropped; err_long=1.
//  5 TAGCHK_EN: corrupt tag of word 17 (expect 1, drive 3) -> err_tag=1, data still forwarded; without the
//    macro err_tag stays 0.
//  6 Reset asserted mid frame 5 -> all outputs 0 next cycle; a new frame after reset starts at sub_idx 0.

Source files
------------

// File: rtl/sdmf_expand_pkg.sv
// sdmf_expand_pkg
//   Shared definitions for the SDMF expand/split block.
//   - state_t     : FSM states of sdmf_expand_split
//   - fdsti_out_w : width of the output frame time index ({input FDSTI, sub-frame index})
package sdmf_expand_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_GAP  = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  function automatic int fdsti_out_w(input int fdsti_w, input int tam_w);
    return fdsti_w + tam_w;
  endfunction

endpackage

// File: rtl/sdmf_expand_cnt.sv
// sdmf_expand_cnt
//   Word counter within a sub-frame and sub-frame index within a merged frame.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     clr         : start of a new merged frame, both counters return to 0
//     word_adv    : one input word accepted
//     sub_adv     : move on to the next sub-frame
//     word_cnt    : current word position inside the sub-frame
//     sub_idx     : current sub-frame index
//     last_word   : word_cnt is at the last word of a sub-frame
//     last_sub    : sub_idx is at the last sub-frame
module sdmf_expand_cnt
  import sdmf_expand_pkg::*;
#(
  parameter int SUB_WORDS_LOG2 = 4,
  parameter int O_TAM_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      word_adv,
  input  logic                      sub_adv,
  output logic [SUB_WORDS_LOG2-1:0] word_cnt,
  output logic [O_TAM_WIDTH-1:0]    sub_idx,
  output logic                      last_word,
  output logic                      last_sub
);

  // word_cnt wraps to 0 naturally after the last word of a sub-frame, so the
  // next sub-frame starts at 0 without an explicit clear.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      word_cnt <= '0;
      sub_idx  <= '0;
    end else begin
      if (word_adv) word_cnt <= word_cnt + 1'b1;
      if (sub_adv)  sub_idx  <= sub_idx + 1'b1;
    end
  end

  assign last_word = &word_cnt;
  assign last_sub  = &sub_idx;

endmodule

// File: rtl/sdmf_expand_split.sv
// sdmf_expand_split
//   Splits one merged SDMF frame (header + 2**O_TAM_WIDTH sub-frames of
//   2**SUB_WORDS_LOG2 words) into individual SDMF frames, each with its own
//   header pulse, FDSTI = {input FDSTI, sub_idx}, and narrowed payload.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     SDMFi_d_*                  : merged input frame (header strobe + AXI-stream)
//     SDMFo_d_*                  : split output frames (header strobe + AXI-stream)
//     err_short / err_long       : sticky framing errors (tlast early / missing)
//     err_tag                    : sticky tag mismatch
//   Optional feature: define SDMF_EXPAND_TAGCHK_EN to build the tag checker,
//   which compares each word's tag field with the current sub-frame index.
//   Without it err_tag is constant 0.
module sdmf_expand_split
  import sdmf_expand_pkg::*;
#(
  parameter int I_FDSTI_WIDTH  = 28,
  parameter int I_FDSSI_WIDTH  = 12,
  parameter int O_TAM_WIDTH    = 4,
  parameter int I_DATA_WIDTH   = 24,
  parameter int O_DATA_WIDTH   = 16,
  parameter int SUB_WORDS_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     SDMFi_d_frame_valid,
  input  logic                     SDMFi_d_FI_valid,
  input  logic [I_FDSTI_WIDTH-1:0] SDMFi_d_FDSTI,
  input  logic [I_FDSSI_WIDTH-1:0] SDMFi_d_FDSSI,
  input  logic                     SDMFi_d_tvalid,
  output logic                     SDMFi_d_tready,
  input  logic                     SDMFi_d_tlast,
  input  logic [I_DATA_WIDTH-1:0]  SDMFi_d_tdata,
  output logic                     SDMFo_d_frame_valid,
  output logic                     SDMFo_d_FI_valid,
  output logic [fdsti_out_w(I_FDSTI_WIDTH, O_TAM_WIDTH)-1:0] SDMFo_d_FDSTI,
  output logic [I_FDSSI_WIDTH-1:0] SDMFo_d_FDSSI,
  output logic                     SDMFo_d_tvalid,
  input  logic                     SDMFo_d_tready,
  output logic                     SDMFo_d_tlast,
  output logic [O_DATA_WIDTH-1:0]  SDMFo_d_tdata,
  output logic                     err_short,
  output logic                     err_long,
  output logic                     err_tag
);

  state_t                    state;
  logic [I_FDSTI_WIDTH-1:0]  fdsti_q;
  logic [I_FDSSI_WIDTH-1:0]  fdssi_q;
  logic                      short_q;
  logic [SUB_WORDS_LOG2-1:0] word_cnt;
  logic [O_TAM_WIDTH-1:0]    sub_idx;
  logic                      last_word;
  logic                      last_sub;
  logic                      in_hs;
  logic                      cnt_clr;
  logic                      word_adv;
  logic                      sub_adv;
  logic                      frame_end;

  // In S_DATA the input is wired straight to the output, so an input
  // handshake is simply input tvalid with output tready.
  assign in_hs     = SDMFi_d_tvalid && SDMFo_d_tready;
  assign cnt_clr   = (state == IDLE) && SDMFi_d_FI_valid;
  assign word_adv  = (state == S_DATA) && in_hs;
  assign sub_adv   = (state == S_GAP) && !short_q && !last_sub;
  // Only the very last word of the last sub-frame may carry input tlast.
  assign frame_end = last_word && last_sub;

  sdmf_expand_cnt #(
    .SUB_WORDS_LOG2(SUB_WORDS_LOG2),
    .O_TAM_WIDTH   (O_TAM_WIDTH)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .word_adv (word_adv),
    .sub_adv  (sub_adv),
    .word_cnt (word_cnt),
    .sub_idx  (sub_idx),
    .last_word(last_word),
    .last_sub (last_sub)
  );

  // Control FSM with registered header/envelope outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      fdsti_q             <= '0;
      fdssi_q             <= '0;
      short_q             <= 1'b0;
      SDMFo_d_frame_valid <= 1'b0;
      SDMFo_d_FI_valid    <= 1'b0;
      err_short           <= 1'b0;
      err_long            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (SDMFi_d_FI_valid) begin
            fdsti_q             <= SDMFi_d_FDSTI;
            fdssi_q             <= SDMFi_d_FDSSI;
            short_q             <= 1'b0;
            SDMFo_d_frame_valid <= 1'b1;
            SDMFo_d_FI_valid    <= 1'b1;
            state               <= S_HDR;
          end
        end
        S_HDR: begin
          SDMFo_d_FI_valid <= 1'b0;
          state            <= S_DATA;
        end
        S_DATA: begin
          if (in_hs) begin
            if (SDMFi_d_tlast && !frame_end) begin
              err_short           <= 1'b1;
              short_q             <= 1'b1;
              SDMFo_d_frame_valid <= 1'b0;
              state               <= S_GAP;
            end else if (last_word) begin
              SDMFo_d_frame_valid <= 1'b0;
              if (last_sub && !SDMFi_d_tlast) begin
                err_long <= 1'b1;
                state    <= DRAIN;
              end else begin
                state <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (short_q || last_sub) begin
            state <= IDLE;
          end else begin
            SDMFo_d_frame_valid <= 1'b1;
            SDMFo_d_FI_valid    <= 1'b1;
            state               <= S_HDR;
          end
        end
        DRAIN: begin
          if (SDMFi_d_tvalid && SDMFi_d_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SDMFo_d_FDSTI = {fdsti_q, sub_idx};
  assign SDMFo_d_FDSSI = fdssi_q;

  // Zero-latency data path; everything is forced to 0 outside S_DATA.
  always_comb begin
    SDMFi_d_tready = 1'b0;
    SDMFo_d_tvalid = 1'b0;
    SDMFo_d_tlast  = 1'b0;
    SDMFo_d_tdata  = '0;
    if (state == S_DATA) begin
      SDMFi_d_tready = SDMFo_d_tready;
      SDMFo_d_tvalid = SDMFi_d_tvalid;
      SDMFo_d_tlast  = SDMFi_d_tvalid && (last_word || SDMFi_d_tlast);
      SDMFo_d_tdata  = SDMFi_d_tdata[O_DATA_WIDTH-1:0];
    end else if (state == DRAIN) begin
      SDMFi_d_tready = 1'b1;
    end
  end

`ifdef SDMF_EXPAND_TAGCHK_EN
  logic err_tag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_tag_q <= 1'b0;
    end else if (word_adv &&
                 (SDMFi_d_tdata[O_DATA_WIDTH+O_TAM_WIDTH-1:O_DATA_WIDTH] != sub_idx)) begin
      err_tag_q <= 1'b1;
    end
  end

  assign err_tag = err_tag_q;
`else
  assign err_tag = 1'b0;
`endif

  // Tag bits (when unchecked) and the input envelope are not needed by the logic.
  logic unused_inputs;
  assign unused_inputs = ^{SDMFi_d_tdata[I_DATA_WIDTH-1:O_DATA_WIDTH], SDMFi_d_frame_valid};

endmodule

// File: tb/tb_sdmf_expand_split.sv
// tb_sdmf_expand_split
//   Scoreboard bench for sdmf_expand_split: expected headers and words are
//   queued as the merged frame is driven and compared when the DUT emits them.
//   Expects err_tag behaviour according to SDMF_EXPAND_TAGCHK_EN.
module tb_sdmf_expand_split;

  localparam int IFW = 28;
  localparam int ISW = 12;
  localparam int TAM = 4;
  localparam int IDW = 24;
  localparam int ODW = 16;
  localparam int SWL = 4;
  localparam int OFW = IFW + TAM;

  logic           clk = 1'b0;
  logic           reset;
  logic           i_fv, i_fi, i_tvalid, i_tready, i_tlast;
  logic [IFW-1:0] i_fdsti;
  logic [ISW-1:0] i_fdssi;
  logic [IDW-1:0] i_tdata;
  logic           o_fv, o_fi, o_tvalid, o_tready, o_tlast;
  logic [OFW-1:0] o_fdsti;
  logic [ISW-1:0] o_fdssi;
  logic [ODW-1:0] o_tdata;
  logic           err_short, err_long, err_tag;

  always #5 clk = ~clk;

  sdmf_expand_split #(
    .I_FDSTI_WIDTH(IFW), .I_FDSSI_WIDTH(ISW), .O_TAM_WIDTH(TAM),
    .I_DATA_WIDTH(IDW), .O_DATA_WIDTH(ODW), .SUB_WORDS_LOG2(SWL)
  ) dut (
    .clk(clk), .reset(reset),
    .SDMFi_d_frame_valid(i_fv), .SDMFi_d_FI_valid(i_fi),
    .SDMFi_d_FDSTI(i_fdsti), .SDMFi_d_FDSSI(i_fdssi),
    .SDMFi_d_tvalid(i_tvalid), .SDMFi_d_tready(i_tready),
    .SDMFi_d_tlast(i_tlast), .SDMFi_d_tdata(i_tdata),
    .SDMFo_d_frame_valid(o_fv), .SDMFo_d_FI_valid(o_fi),
    .SDMFo_d_FDSTI(o_fdsti), .SDMFo_d_FDSSI(o_fdssi),
    .SDMFo_d_tvalid(o_tvalid), .SDMFo_d_tready(o_tready),
    .SDMFo_d_tlast(o_tlast), .SDMFo_d_tdata(o_tdata),
    .err_short(err_short), .err_long(err_long), .err_tag(err_tag)
  );

  typedef struct packed {
    logic [OFW-1:0] fdsti;
    logic [ODW-1:0] data;
    logic           last;
  } wexp_t;

  typedef struct packed {
    logic [OFW-1:0] fdsti;
    logic [ISW-1:0] fdssi;
  } hexp_t;

  wexp_t wq[$];
  hexp_t hq[$];
  wexp_t mw;
  hexp_t mh;

  int  n_chk = 0;
  int  n_fail = 0;
  int  hdr_seen, words_seen, lasts_seen;
  bit  gap_pend;
  bit  bp_mode;
  logic exp_tag;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output tready: always 1, or toggling every cycle when bp_mode is set
  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) o_tready = ~o_tready;
      else         o_tready = 1'b1;
    end
  end

  // Monitor: sample outputs mid-cycle and compare against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (gap_pend) begin
        check_eq("gap_frame_valid", o_fv, 0);
        check_eq("gap_tvalid", o_tvalid, 0);
        gap_pend = 0;
      end
      if (o_fi) begin
        hdr_seen++;
        if (hq.size() == 0) begin
          check_eq("hdr_unexpected", 1, 0);
        end else begin
          mh = hq.pop_front();
          check_eq("hdr_fdsti", o_fdsti, mh.fdsti);
          check_eq("hdr_fdssi", o_fdssi, mh.fdssi);
          check_eq("hdr_frame_valid", o_fv, 1);
        end
      end
      if (o_tvalid && o_tready) begin
        words_seen++;
        if (o_tlast) begin
          lasts_seen++;
          gap_pend = 1;
        end
        if (wq.size() == 0) begin
          check_eq("word_unexpected", 1, 0);
        end else begin
          mw = wq.pop_front();
          check_eq("word_data", o_tdata, mw.data);
          check_eq("word_tlast", o_tlast, mw.last);
          check_eq("word_fdsti", o_fdsti, mw.fdsti);
          check_eq("word_frame_valid", o_fv, 1);
        end
      end
    end
  end

  task automatic clear_stats();
    hdr_seen   = 0;
    words_seen = 0;
    lasts_seen = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    i_fi     = 1'b0;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    gap_pend = 0;
    wq.delete();
    hq.delete();
    clear_stats();
  endtask

  // Drive one merged frame. Words up to the last expected output word are
  // scoreboarded; tlast_at is the index carrying input tlast; corrupt_idx gets
  // a wrong tag; stop_at abandons the frame before that word.
  task automatic send_frame(input logic [IFW-1:0] base, input logic [ISW-1:0] fdssi,
                            input int nwords, input int tlast_at, input int corrupt_idx,
                            input int stop_at, input bit in_gaps);
    int             lim;
    int             cyc;
    bit             hs;
    logic [TAM-1:0] tagv;
    logic [IDW-1:0] d;
    lim = (tlast_at < 256) ? tlast_at : 255;
    @(posedge clk);
    #1;
    i_fi    = 1'b1;
    i_fv    = 1'b1;
    i_fdsti = base;
    i_fdssi = fdssi;
    @(posedge clk);
    #1;
    i_fi    = 1'b0;
    i_fdsti = IFW'($urandom);
    for (int k = 0; k < nwords; k++) begin
      if (k == stop_at) break;
      tagv = TAM'(k / 16);
      if (k == corrupt_idx) tagv = TAM'(3);
      d = {4'($urandom), tagv, 16'($urandom)};
      if (k <= lim) begin
        if (k % 16 == 0) hq.push_back('{fdsti: {base, TAM'(k / 16)}, fdssi: fdssi});
        wq.push_back('{fdsti: {base, TAM'(k / 16)}, data: d[ODW-1:0],
                       last: (k % 16 == 15) || (k == tlast_at)});
      end
      if (in_gaps && (k % 5 == 2)) begin
        i_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      i_tvalid = 1'b1;
      i_tdata  = d;
      i_tlast  = (k == tlast_at);
      cyc = 0;
      hs  = 0;
      while (!hs && cyc < 2000) begin
        @(negedge clk);
        hs = i_tready;
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!hs) begin
        check_eq("handshake_timeout", 0, 1);
        break;
      end
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    i_fv     = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    i_fv     = 1'b0;
    i_fi     = 1'b0;
    i_fdsti  = '0;
    i_fdssi  = '0;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    i_tdata  = '0;
    bp_mode  = 1'b0;
    gap_pend = 0;
`ifdef SDMF_EXPAND_TAGCHK_EN
    exp_tag = 1'b1;
`else
    exp_tag = 1'b0;
`endif
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_frame_valid", o_fv, 0);
    check_eq("rst_fi_valid", o_fi, 0);
    check_eq("rst_fdsti", o_fdsti, 0);
    check_eq("rst_in_tready", i_tready, 0);
    check_eq("rst_err", {err_short, err_long, err_tag}, 0);
    reset = 1'b0;

    // 1: nominal frame
    clear_stats();
    send_frame(28'h0000123, 12'h005, 256, 255, -1, -1, 1'b0);
    settle();
    check_eq("t1_headers", hdr_seen, 16);
    check_eq("t1_words", words_seen, 256);
    check_eq("t1_lasts", lasts_seen, 16);
    check_eq("t1_queue_empty", wq.size() + hq.size(), 0);
    check_eq("t1_errors", {err_short, err_long, err_tag}, 0);

    // 2: output backpressure plus input gaps
    clear_stats();
    bp_mode = 1'b1;
    send_frame(28'h0ABCDEF, 12'hA5C, 256, 255, -1, -1, 1'b1);
    settle();
    bp_mode = 1'b0;
    check_eq("t2_headers", hdr_seen, 16);
    check_eq("t2_words", words_seen, 256);
    check_eq("t2_lasts", lasts_seen, 16);
    check_eq("t2_queue_empty", wq.size() + hq.size(), 0);
    check_eq("t2_errors", {err_short, err_long}, 0);

    // 3: early tlast on word 40, then a clean frame
    do_reset();
    send_frame(28'h0000456, 12'h011, 41, 40, -1, -1, 1'b0);
    settle();
    check_eq("t3_headers", hdr_seen, 3);
    check_eq("t3_words", words_seen, 41);
    check_eq("t3_lasts", lasts_seen, 3);
    check_eq("t3_err_short", err_short, 1);
    check_eq("t3_err_long", err_long, 0);
    clear_stats();
    send_frame(28'h0000457, 12'h012, 256, 255, -1, -1, 1'b0);
    settle();
    check_eq("t3b_headers", hdr_seen, 16);
    check_eq("t3b_words", words_seen, 256);
    check_eq("t3b_queue_empty", wq.size() + hq.size(), 0);

    // 4: missing tlast at word 255, tlast at 260
    do_reset();
    send_frame(28'h0000789, 12'h033, 261, 260, -1, -1, 1'b0);
    settle();
    check_eq("t4_headers", hdr_seen, 16);
    check_eq("t4_words", words_seen, 256);
    check_eq("t4_err_long", err_long, 1);
    check_eq("t4_err_short", err_short, 0);
    check_eq("t4_idle_tready", i_tready, 0);

    // 5: corrupted tag on word 17
    do_reset();
    send_frame(28'h0000ABC, 12'h044, 256, 255, 17, -1, 1'b0);
    settle();
    check_eq("t5_words", words_seen, 256);
    check_eq("t5_err_tag", err_tag, exp_tag);
    check_eq("t5_queue_empty", wq.size() + hq.size(), 0);

    // 6: reset in the middle of sub-frame 5
    do_reset();
    send_frame(28'h0000DEF, 12'h055, 256, 255, -1, 83, 1'b0);
    check_eq("t6_prereset_fdsti", o_fdsti, {28'h0000DEF, 4'd5});
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t6_frame_valid", o_fv, 0);
    check_eq("t6_fi_valid", o_fi, 0);
    check_eq("t6_fdsti", o_fdsti, 0);
    check_eq("t6_fdssi", o_fdssi, 0);
    check_eq("t6_stream", {o_tvalid, o_tlast, o_tdata, i_tready}, 0);
    reset    = 1'b0;
    gap_pend = 0;
    wq.delete();
    hq.delete();
    clear_stats();
    send_frame(28'h0000777, 12'h066, 256, 255, -1, -1, 1'b0);
    settle();
    check_eq("t6_after_headers", hdr_seen, 16);
    check_eq("t6_after_words", words_seen, 256);
    check_eq("t6_after_queue_empty", wq.size() + hq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
